product_accumulator: RTL
========================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter P_W, default 64, meaning signed product width from the upstream multiplier.
REQ-002 SHALL have parameter LEN_W, default 8, meaning width of the block-length field.
REQ-003 SHALL have parameter ACC_W, default P_W+LEN_W, meaning internal accumulator width, so no internal overflow can occur.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 p_valid  input  1  product word present on p.
REQ-007 p_ready  output  1  block can accept a product this cycle.
REQ-008 p  input  P_W  signed product, two's complement.
REQ-009 len  input  LEN_W  number of products per block; sampled only on the first accept of a block.
REQ-010 out_valid  output  1  accumulated result available.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 acc_out  output  P_W  signed sum, saturated to the P_W range.
REQ-013 sat  output  1  the full-width sum was outside the P_W signed range.
REQ-014 cnt_out  output  LEN_W  number of products summed into acc_out.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-016 Product transfer SHALL occur only on a cycle with p_valid=1 and p_ready=1; p_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD.
REQ-017 IDLE transfer SHALL do all of the following:
- load the accumulator with sign-extended p;
- set cnt=1;
- latch len, with len=0 treated as 1;
- go to HOLD if the latched length is 1, else go to ACCUM.
REQ-018 ACCUM transfer SHALL add sign-extended p to the accumulator and increment cnt; when the new cnt equals the latched length, the state SHALL go to HOLD.
REQ-019 ACCUM cycles with no transfer SHALL leave all state unchanged; p_valid gaps are unlimited.
REQ-020 out_valid SHALL be 1 exactly in HOLD, asserted the cycle after the final product transfer (latency 1).
REQ-021 In HOLD, acc_out, sat and cnt_out SHALL stay stable until out_valid=1 and out_ready=1; on that cycle the state SHALL go to IDLE.
REQ-022 The product offered on the cycle HOLD exits SHALL NOT be consumed that cycle; there is no same-cycle bypass.
REQ-023 Saturation rule for acc_out:
- accumulator > 2^(P_W-1)-1 gives the max positive value;
- accumulator < -2^(P_W-1) gives the max negative value;
- otherwise the low P_W bits.
sat SHALL be 1 exactly when clamping applies.
REQ-024 Outside HOLD, acc_out, sat and cnt_out SHALL be 0.
REQ-025 len changes after the first accept of a block SHALL have no effect on that block.

Reset
REQ-026 rst=1 SHALL force IDLE and set accumulator=0, cnt=0, latched length=0, out_valid=0, acc_out=0, sat=0 and cnt_out=0 on the next edge, with p_ready=1 after release.
REQ-027 rst SHALL take priority over any simultaneous transfer; a partial block SHALL be discarded with no output.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/ACCUM/HOLD) and the default P_W/LEN_W constants, for reuse by the multiplier-path blocks.
REQ-029 Saturation SHALL be one sub-module, sat_clamp: ACC_W in, P_W out plus an overflow flag, purely combinational.

Verification
REQ-030 len=3; products 10*-150=-1500, 100, -100 with p_valid gaps -> one cycle after the third accept, out_valid=1, acc_out=-1500, sat=0, cnt_out=3.
REQ-031 len=0, p=150 -> treated as len 1: out_valid the next cycle, acc_out=150, cnt_out=1.
REQ-032 len=2, p=0x7FFF_FFFF_FFFF_FFFF twice -> acc_out=0x7FFF_FFFF_FFFF_FFFF, sat=1; repeat with 0x8000_0000_0000_0000 twice -> acc_out=0x8000_0000_0000_0000, sat=1.
REQ-033 Hold out_ready=0 for 5 cycles in HOLD while p_valid=1 -> p_ready=0 and outputs stable; raise out_ready -> IDLE next cycle, and the next block sums correctly from 0.
REQ-034 len=4; assert rst after 2 accepts -> no out_valid; after release, block len=1, p=-7 -> acc_out=-7, cnt_out=1.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// ============================================================================
// Module : product_accumulator_pkg
// Brief  : Shared state encoding and default widths for the product path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package product_accumulator_pkg;

    localparam int C_P_W_DEFAULT   = 64;
    localparam int C_LEN_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/product_accumulator_sat_clamp.sv
// ============================================================================
// Module : sat_clamp
// Brief  : Clamps a wide signed accumulator into the P_W signed range.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_clamp #(
    parameter int ACC_W = 72,
    parameter int P_W   = 64
) (
    input  logic [ACC_W-1:0] i_acc,
    output logic [P_W-1:0]   o_val,
    output logic             o_ovf
);

    logic [ACC_W-P_W:0] w_upper;
    logic               w_fits;

    // The value fits when every bit from the P_W sign bit upward agrees.
    assign w_upper = i_acc[ACC_W-1:P_W-1];
    assign w_fits  = (w_upper == '0) || (w_upper == '1);

    always_comb begin
        o_ovf = !w_fits;
        o_val = i_acc[P_W-1:0];
        if (!w_fits) begin
            o_val = i_acc[ACC_W-1] ? {1'b1, {(P_W-1){1'b0}}}
                                   : {1'b0, {(P_W-1){1'b1}}};
        end
    end

endmodule

`default_nettype wire

// File: rtl/product_accumulator.sv
// ============================================================================
// Module : product_accumulator
// Brief  : Sums a block of signed products and presents a saturated result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int P_W   = C_P_W_DEFAULT,
    parameter int LEN_W = C_LEN_W_DEFAULT,
    parameter int ACC_W = P_W + LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [P_W-1:0]   p,
    input  logic [LEN_W-1:0] len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P_W-1:0]   acc_out,
    output logic             sat,
    output logic [LEN_W-1:0] cnt_out
);

    state_e             r_state_q,     w_state_d;
    logic [ACC_W-1:0]   r_acc_q,       w_acc_d;
    logic [LEN_W-1:0]   r_cnt_q,       w_cnt_d;
    logic [LEN_W-1:0]   r_len_q,       w_len_d;
    logic               r_p_ready_q,   w_p_ready_d;
    logic               r_out_valid_q, w_out_valid_d;
    logic [P_W-1:0]     r_acc_out_q,   w_acc_out_d;
    logic               r_sat_q,       w_sat_d;
    logic [LEN_W-1:0]   r_cnt_out_q,   w_cnt_out_d;

    logic [ACC_W-1:0]   w_p_ext;
    logic [LEN_W-1:0]   w_len_eff;
    logic [P_W-1:0]     w_clamp_val;
    logic               w_clamp_ovf;

    assign w_p_ext   = {{(ACC_W-P_W){p[P_W-1]}}, p};
    assign w_len_eff = (len == '0) ? LEN_W'(1) : len;

    // Clamp the next accumulator value so the outputs can be registered.
    sat_clamp #(
        .ACC_W (ACC_W),
        .P_W   (P_W)
    ) u_sat_clamp (
        .i_acc (w_acc_d),
        .o_val (w_clamp_val),
        .o_ovf (w_clamp_ovf)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_acc_d   = r_acc_q;
        w_cnt_d   = r_cnt_q;
        w_len_d   = r_len_q;
        case (r_state_q)
            IDLE: begin
                if (p_valid) begin
                    w_acc_d   = w_p_ext;
                    w_cnt_d   = LEN_W'(1);
                    w_len_d   = w_len_eff;
                    w_state_d = (w_len_eff == LEN_W'(1)) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (p_valid) begin
                    w_acc_d = r_acc_q + w_p_ext;
                    w_cnt_d = r_cnt_q + LEN_W'(1);
                    if (w_cnt_d == r_len_q) begin
                        w_state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase

        w_p_ready_d   = (w_state_d != HOLD);
        w_out_valid_d = (w_state_d == HOLD);
        w_acc_out_d   = (w_state_d == HOLD) ? w_clamp_val : '0;
        w_sat_d       = (w_state_d == HOLD) ? w_clamp_ovf : 1'b0;
        w_cnt_out_d   = (w_state_d == HOLD) ? w_cnt_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_acc_q       <= '0;
            r_cnt_q       <= '0;
            r_len_q       <= '0;
            r_p_ready_q   <= 1'b1;
            r_out_valid_q <= 1'b0;
            r_acc_out_q   <= '0;
            r_sat_q       <= 1'b0;
            r_cnt_out_q   <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_acc_q       <= w_acc_d;
            r_cnt_q       <= w_cnt_d;
            r_len_q       <= w_len_d;
            r_p_ready_q   <= w_p_ready_d;
            r_out_valid_q <= w_out_valid_d;
            r_acc_out_q   <= w_acc_out_d;
            r_sat_q       <= w_sat_d;
            r_cnt_out_q   <= w_cnt_out_d;
        end
    end

    assign p_ready   = r_p_ready_q;
    assign out_valid = r_out_valid_q;
    assign acc_out   = r_acc_out_q;
    assign sat       = r_sat_q;
    assign cnt_out   = r_cnt_out_q;

endmodule

`default_nettype wire
